// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - fetch-stage PC sequencer with stall, redirect, flush and halt drain
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD    = 32'hFFFF_FFFF,
    parameter int unsigned DRAIN_CYCLES = 7
) (
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic        Stall,
    input  logic        Redirect_valid,
    input  logic [1:0]  Redirect_kind,
    input  logic [31:0] Branch_target,
    input  logic [31:0] Jump_target,
    input  logic [31:0] Jr_target,
    input  logic [31:0] Inst_in,
    output logic [31:0] PC_out,
    output logic [31:0] Inst_out,
    output logic        Inst_valid,
    output logic        Flush,
    output logic        fin_sign,
    output logic [15:0] Redirect_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

    state_t      state, state_nx;
    logic [7:0]  drain_cnt, drain_cnt_nx;
    logic [31:0] pc_nx;
    logic [15:0] redirect_cnt_nx;
    logic        fin_nx;
    logic        redirect_acc;
    logic [31:0] redirect_target;

    assign redirect_acc = Redirect_valid && (Redirect_kind != 2'b00);

    always_comb begin
        redirect_target = Branch_target;
        case (Redirect_kind)
            2'b10:   redirect_target = Jump_target;
            2'b11:   redirect_target = Jr_target;
            default: redirect_target = Branch_target;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= RUN;
            PC_out       <= RESET_PC;
            drain_cnt    <= 8'd0;
            Redirect_cnt <= 16'd0;
            fin_sign     <= 1'b0;
        end else begin
            state        <= state_nx;
            PC_out       <= pc_nx;
            drain_cnt    <= drain_cnt_nx;
            Redirect_cnt <= redirect_cnt_nx;
            fin_sign     <= fin_nx;
        end
    end

    always_comb begin
        state_nx        = state;
        pc_nx           = PC_out;
        drain_cnt_nx    = drain_cnt;
        redirect_cnt_nx = Redirect_cnt;
        fin_nx          = fin_sign;
        Flush           = 1'b0;
        Inst_valid      = 1'b0;
        case (state)
            RUN: begin
                // Redirect outranks a fetched halt word: that word is on the wrong path.
                if (!Stall) begin
                    if (redirect_acc) begin
                        pc_nx = {redirect_target[31:2], 2'b00};
                        Flush = 1'b1;
                        if (Redirect_cnt != 16'hFFFF) begin
                            redirect_cnt_nx = Redirect_cnt + 16'd1;
                        end
                    end else if (Inst_in == HALT_WORD) begin
                        state_nx     = DRAIN;
                        drain_cnt_nx = 8'd0;
                    end else begin
                        Inst_valid = 1'b1;
                        pc_nx      = PC_out + 32'd4;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    state_nx = DONE;
                    fin_nx   = 1'b1;
                end else begin
                    drain_cnt_nx = drain_cnt + 8'd1;
                end
            end
            DONE: begin
                fin_nx = 1'b1;
            end
            default: begin
                state_nx = RUN;
            end
        endcase
    end

    assign Inst_out = Inst_valid ? Inst_in : 32'd0;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb/tb_if_fetch_ctrl.sv - self-checking bench for if_fetch_ctrl
module tb_if_fetch_ctrl;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam int          DRAIN = 7;

    logic        CLOCK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        Stall = 1'b0;
    logic        Redirect_valid = 1'b0;
    logic [1:0]  Redirect_kind = 2'b00;
    logic [31:0] Branch_target = '0;
    logic [31:0] Jump_target = '0;
    logic [31:0] Jr_target = '0;
    logic [31:0] Inst_in = '0;
    logic [31:0] PC_out;
    logic [31:0] Inst_out;
    logic        Inst_valid;
    logic        Flush;
    logic        fin_sign;
    logic [15:0] Redirect_cnt;

    if_fetch_ctrl dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .Stall(Stall),
        .Redirect_valid(Redirect_valid), .Redirect_kind(Redirect_kind),
        .Branch_target(Branch_target), .Jump_target(Jump_target), .Jr_target(Jr_target),
        .Inst_in(Inst_in), .PC_out(PC_out), .Inst_out(Inst_out), .Inst_valid(Inst_valid),
        .Flush(Flush), .fin_sign(fin_sign), .Redirect_cnt(Redirect_cnt)
    );

    always #5 CLOCK = ~CLOCK;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: mode 0 fetching, 1 draining, 2 finished.
    logic [31:0] m_pc;
    int          m_mode;
    int          m_left;
    int          m_rc;
    logic        m_fin;

    typedef struct {
        logic        stall;
        logic        rv;
        logic [1:0]  kind;
        logic [31:0] bt, jt, jrt, inst;
        logic        e_flush, e_valid;
        logic [31:0] e_out, e_pc;
        logic [15:0] e_rc;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic rv, input logic [1:0] k,
                         input logic [31:0] bt, input logic [31:0] jt,
                         input logic [31:0] jrt, input logic [31:0] inst);
        Stall = st; Redirect_valid = rv; Redirect_kind = k;
        Branch_target = bt; Jump_target = jt; Jr_target = jrt; Inst_in = inst;
    endtask

    // Called at posedge+1; asserts reset, checks async values, releases before the next edge.
    task automatic do_reset();
        RESET_N = 1'b0;
        #2;
        chk("rst_pc", PC_out, 32'h0);
        chk("rst_fin", {31'd0, fin_sign}, 32'd0);
        chk("rst_rc", {16'd0, Redirect_cnt}, 32'd0);
        RESET_N = 1'b1;
        m_pc = 32'h0; m_mode = 0; m_left = 0; m_rc = 0; m_fin = 1'b0;
    endtask

    // Called at posedge+1 with inputs driven; checks the cycle against the model.
    task automatic cycle_check();
        logic        acc, e_valid;
        logic [31:0] tgt;
        @(negedge CLOCK);
        acc = (m_mode == 0) && !Stall && Redirect_valid && (Redirect_kind != 2'b00);
        e_valid = (m_mode == 0) && !Stall && !acc && (Inst_in != HALT);
        chk("flush", {31'd0, Flush}, {31'd0, acc});
        chk("valid", {31'd0, Inst_valid}, {31'd0, e_valid});
        chk("inst_out", Inst_out, e_valid ? Inst_in : 32'd0);
        tgt = (Redirect_kind == 2'b01) ? Branch_target :
              (Redirect_kind == 2'b10) ? Jump_target : Jr_target;
        @(posedge CLOCK);
        if (m_mode == 0 && !Stall) begin
            if (acc) begin
                m_pc = tgt & 32'hFFFF_FFFC;
                if (m_rc < 65535) m_rc++;
            end else if (Inst_in == HALT) begin
                m_mode = 1;
                m_left = DRAIN;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end else if (m_mode == 1) begin
            m_left--;
            if (m_left == 0) begin
                m_mode = 2;
                m_fin = 1'b1;
            end
        end
        #1;
        chk("pc", PC_out, m_pc);
        chk("fin", {31'd0, fin_sign}, {31'd0, m_fin});
        chk("rc", {16'd0, Redirect_cnt}, 32'(m_rc));
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h1234, 1'b0, 1'b1, 32'h1234, 32'h4, 16'd0};
        tbl[1] = '{1'b1, 1'b1, 2'b01, 32'h40, 32'h0, 32'h0, 32'h55, 1'b0, 1'b0, 32'h0, 32'h0, 16'd0};
        tbl[2] = '{1'b0, 1'b1, 2'b01, 32'h40, 32'h0, 32'h0, 32'h55, 1'b1, 1'b0, 32'h0, 32'h40, 16'd1};
        tbl[3] = '{1'b0, 1'b1, 2'b11, 32'h0, 32'h0, 32'h83, 32'h55, 1'b1, 1'b0, 32'h0, 32'h80, 16'd1};
        tbl[4] = '{1'b0, 1'b1, 2'b10, 32'h0, 32'h101, 32'h0, HALT, 1'b1, 1'b0, 32'h0, 32'h100, 16'd1};
        tbl[5] = '{1'b0, 1'b1, 2'b00, 32'h40, 32'h0, 32'h0, 32'hAB, 1'b0, 1'b1, 32'hAB, 32'h4, 16'd0};
        tbl[6] = '{1'b0, 1'b0, 2'b01, 32'h40, 32'h0, 32'h0, 32'hCD, 1'b0, 1'b1, 32'hCD, 32'h4, 16'd0};
        tbl[7] = '{1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, HALT, 1'b0, 1'b0, 32'h0, 32'h0, 16'd0};
        tbl[8] = '{1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, HALT, 1'b0, 1'b0, 32'h0, 32'h0, 16'd0};

        @(posedge CLOCK); #1;
        for (int i = 0; i < 9; i++) begin
            do_reset();
            drive(tbl[i].stall, tbl[i].rv, tbl[i].kind, tbl[i].bt, tbl[i].jt, tbl[i].jrt, tbl[i].inst);
            @(negedge CLOCK);
            chk($sformatf("tbl%0d_flush", i), {31'd0, Flush}, {31'd0, tbl[i].e_flush});
            chk($sformatf("tbl%0d_valid", i), {31'd0, Inst_valid}, {31'd0, tbl[i].e_valid});
            chk($sformatf("tbl%0d_out", i), Inst_out, tbl[i].e_out);
            @(posedge CLOCK); #1;
            chk($sformatf("tbl%0d_pc", i), PC_out, tbl[i].e_pc);
            chk($sformatf("tbl%0d_rc", i), {16'd0, Redirect_cnt}, {16'd0, tbl[i].e_rc});
            chk($sformatf("tbl%0d_fin", i), {31'd0, fin_sign}, 32'd0);
        end

        // Sequential fetch, then branch at 0x10 and jr with misaligned target.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 2'b00, 0, 0, 0, 32'h2000_0000 + 32'(i));
            cycle_check();
            chk("seq_pc", PC_out, 32'(4 * (i + 1)));
        end
        drive(1'b0, 1'b1, 2'b01, 32'h40, 0, 0, 32'h1);
        cycle_check();
        chk("br_pc", PC_out, 32'h40);
        chk("br_rc", {16'd0, Redirect_cnt}, 32'd1);
        drive(1'b0, 1'b1, 2'b11, 0, 0, 32'h83, 32'h1);
        cycle_check();
        chk("jr_pc", PC_out, 32'h80);
        chk("jr_rc", {16'd0, Redirect_cnt}, 32'd2);

        // Stall with a pending redirect at 0x8 for three cycles.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 2'b00, 0, 0, 0, 32'h7);
            cycle_check();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 2'b01, 32'h400, 0, 0, 32'h7);
            cycle_check();
            chk("stall_pc", PC_out, 32'h8);
            chk("stall_rc", {16'd0, Redirect_cnt}, 32'd0);
        end
        drive(1'b0, 1'b0, 2'b00, 0, 0, 0, 32'h7);
        cycle_check();
        chk("unstall_pc", PC_out, 32'hC);

        // Halt at 0x20, redirect attempts while draining, then reset in DONE.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 2'b00, 0, 0, 0, 32'h9);
            cycle_check();
        end
        drive(1'b0, 1'b0, 2'b00, 0, 0, 0, HALT);
        cycle_check();
        for (int i = 1; i <= DRAIN; i++) begin
            drive(1'b0, 1'b1, 2'b10, 0, 32'h200, 0, 32'h9);
            cycle_check();
            chk("drain_fin", {31'd0, fin_sign}, {31'd0, (i == DRAIN)});
            chk("drain_pc", PC_out, 32'h20);
        end
        chk("done_rc", {16'd0, Redirect_cnt}, 32'd0);
        do_reset();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if (m_mode == 2 && $urandom_range(0, 3) == 0) do_reset();
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, 2'($urandom),
                  $urandom, $urandom, $urandom,
                  ($urandom_range(0, 15) == 0) ? HALT : $urandom);
            cycle_check();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Fetch-stage sequencer for the pipelined MIPS core. It owns the program counter, chooses each cycle between sequential fetch, hold (hazard stall) and redirect (taken beq/bne, j/jal, jr resolved in ID), and flushes the IF/ID register on redirect. It also detects the end-of-program word, drains the pipeline for a fixed number of cycles, then raises a sticky finish flag. It sits between the instruction memory (PC out, instruction in) and the IF/ID pipeline register.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- HALT_WORD, 32'hFFFF_FFFF, instruction word that marks end of program
- DRAIN_CYCLES, 7, cycles spent in DRAIN before fin_sign rises (1..255)

- CLOCK  in  1  rising-edge clock
- RESET_N  in  1  reset; asynchronous and active-low
- Stall  in  1  hazard unit hold request; freezes PC
- Redirect_valid  in  1  ID has resolved a taken branch/jump this cycle
- Redirect_kind  in  2  01 branch, 10 j/jal, 11 jr; 00 treated as no redirect
- Branch_target  in  32  beq/bne target
- Jump_target  in  32  j/jal target
- Jr_target  in  32  forwarded register value for jr
- Inst_in  in  32  instruction memory read data at PC_out
- PC_out  out  32  current fetch address to instruction memory
- Inst_out  out  32  instruction to IF/ID (zero when Inst_valid=0)
- Inst_valid  out  1  IF/ID may capture a real instruction
- Flush  out  1  IF/ID must load a bubble this edge
- fin_sign  out  1  program finished; sticky until reset
- Redirect_cnt  out  16  number of accepted redirects, saturating

## Operation
- States: RUN, DRAIN, DONE. Reset -> RUN.
- RUN, per cycle, priority order:
  - Stall=1: PC held; Flush=0; redirect ignored (ID re-presents it after stall clears).
  - Redirect accepted (Redirect_valid=1, Redirect_kind!=00): PC <= selected target with bits [1:0] forced to 0; Flush=1; Inst_valid=0; Redirect_cnt += 1 (saturates at 16'hFFFF).
  - Inst_in == HALT_WORD: state -> DRAIN; PC held; Inst_valid=0; drain counter <= 0.
  - Otherwise: PC <= PC_out + 4 (mod 2^32); Inst_valid=1; Inst_out=Inst_in.
- A redirect in the same cycle as a fetched HALT_WORD wins: the halt word is on the wrong path and is discarded.
- DRAIN: PC frozen; Inst_valid=0; Flush=0; Stall and redirects ignored; counter increments each cycle; when counter == DRAIN_CYCLES-1 -> DONE.
- DONE: fin_sign=1; PC frozen; Inst_valid=0; remains until reset.
- Flush = (state==RUN) && !Stall && redirect accepted. Inst_valid = (state==RUN) && !Stall && no accepted redirect && Inst_in!=HALT_WORD.

## Timing
- Reset values (asynchronous, immediate on RESET_N=0): PC_out=RESET_PC, state=RUN, drain counter=0, fin_sign=0, Redirect_cnt=0.
- Reset asserted mid-DRAIN or in DONE returns to RUN with fin_sign=0 immediately; fetch restarts at RESET_PC on the first edge after release.
- Inst_out, Inst_valid and Flush are combinational from state, Stall, Redirect_* and Inst_in; PC_out, state, counters and fin_sign are registered.
- Redirect latency: target appears on PC_out one edge after the accepting cycle; exactly one bubble enters IF/ID.
- Halt latency: fin_sign rises DRAIN_CYCLES edges after the edge that enters DRAIN.
- Stall held for N cycles holds PC_out constant for N cycles; no instruction is lost or duplicated.

## Test plan
- Reset, Inst_in=sequential non-halt words, no stall/redirect -> PC_out 0,4,8,12 on successive edges, Inst_valid=1 each cycle.
- At PC=0x10 assert Redirect_valid, kind=01, Branch_target=0x40 -> Flush=1 and Inst_valid=0 that cycle, next PC_out=0x40, Redirect_cnt=1; repeat with kind=11, Jr_target=0x83 -> PC_out=0x80.
- Stall=1 for 3 cycles at PC=0x8 with Redirect_valid=1 -> PC_out stays 0x8, Flush=0, Redirect_cnt unchanged.
- Inst_in=32'hFFFFFFFF at PC=0x20, no redirect -> Inst_valid=0, PC frozen at 0x20, fin_sign=1 exactly 7 edges later; a redirect during DRAIN has no effect.
- HALT_WORD and accepted redirect (kind=10, Jump_target=0x100) in same cycle -> PC_out=0x100, state stays RUN, fin_sign stays 0.
- RESET_N pulsed low in DONE -> fin_sign=0, PC_out=RESET_PC, Redirect_cnt=0 without waiting for a clock edge.
